// File: rtl/box_plot_arbiter_pkg.sv
// ============================================================================
// Module : box_plot_arbiter_pkg
// Brief  : Shared screen geometry, pixel field widths and arbiter state codes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package box_plot_arbiter_pkg;

    localparam int DEF_XSCREEN = 160;
    localparam int DEF_YSCREEN = 120;
    localparam int XW          = 8;
    localparam int YW          = 7;
    localparam int CW          = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DRAW = 1'b1
    } bpa_state_e;

    // Index width that stays legal (>=1 bit) for single-entry ranges.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/box_plot_arbiter_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin picker: first set request at or after ptr.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import box_plot_arbiter_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = clog2_min1(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);

    int w_k;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        w_k     = 0;
        for (int i = 0; i < N; i++) begin
            w_k = int'(ptr_i) + i;
            if (w_k >= N) begin
                w_k = w_k - N;
            end
            if (!valid_o && req_i[w_k]) begin
                valid_o    = 1'b1;
                gnt_o[w_k] = 1'b1;
                idx_o      = PW'(w_k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/box_plot_arbiter.sv
// ============================================================================
// Module : box_plot_arbiter
// Brief  : Round-robin shares the VGA pixel port and rasters one box per grant.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module box_plot_arbiter
    import box_plot_arbiter_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int XDIM    = 10,
    parameter int YDIM    = 10,
    parameter int XSCREEN = DEF_XSCREEN,
    parameter int YSCREEN = DEF_YSCREEN
) (
    input  logic               CLOCK_50,
    input  logic               Resetn,
    input  logic [NREQ-1:0]    req,
    input  logic [XW*NREQ-1:0] req_x,
    input  logic [YW*NREQ-1:0] req_y,
    input  logic [CW*NREQ-1:0] req_colour,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic [XW-1:0]      VGA_X,
    output logic [YW-1:0]      VGA_Y,
    output logic [CW-1:0]      VGA_COLOR,
    output logic               plot
);

    localparam int PW  = clog2_min1(NREQ);
    localparam int CXW = clog2_min1(XDIM);
    localparam int CYW = clog2_min1(YDIM);
    localparam int SXW = XW + 1;
    localparam int SYW = YW + 1;
    localparam logic [CXW-1:0] CX_LAST = CXW'(XDIM - 1);
    localparam logic [CYW-1:0] CY_LAST = CYW'(YDIM - 1);

    bpa_state_e       state_q;
    logic [PW-1:0]    ptr_q;
    logic [NREQ-1:0]  owner_q;
    logic [XW-1:0]    bx_q;
    logic [YW-1:0]    by_q;
    logic [CW-1:0]    col_q;
    logic [CXW-1:0]   cx_q;
    logic [CYW-1:0]   cy_q;
    logic [NREQ-1:0]  grant_q;
    logic [NREQ-1:0]  done_q;
    logic             busy_q;
    logic             plot_q;
    logic [XW-1:0]    vga_x_q;
    logic [YW-1:0]    vga_y_q;
    logic [CW-1:0]    vga_c_q;

    logic [NREQ-1:0]  arb_gnt;
    logic [PW-1:0]    arb_idx;
    logic             arb_valid;
    logic [XW-1:0]    win_x;
    logic [YW-1:0]    win_y;
    logic [CW-1:0]    win_c;

    logic [CXW-1:0]   cx_d;
    logic [CYW-1:0]   cy_d;
    logic [XW-1:0]    pbx;
    logic [YW-1:0]    pby;
    logic [CXW-1:0]   pcx;
    logic [CYW-1:0]   pcy;
    logic [SXW-1:0]   sum_x;
    logic [SYW-1:0]   sum_y;
    logic             pix_in_screen;
    logic             pix_last;
    logic             cur_last;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign win_x = req_x[int'(arb_idx)*XW +: XW];
    assign win_y = req_y[int'(arb_idx)*YW +: YW];
    assign win_c = req_colour[int'(arb_idx)*CW +: CW];

    assign cur_last = (cx_q == CX_LAST) && (cy_q == CY_LAST);

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (cx_q == CX_LAST) begin
            cx_d = '0;
            cy_d = cy_q + 1'b1;
        end else begin
            cx_d = cx_q + 1'b1;
        end
    end

    // The pixel registered at the coming edge: box origin when granting,
    // otherwise the advanced counters of the box in flight.
    always_comb begin
        pbx = bx_q;
        pby = by_q;
        pcx = cx_d;
        pcy = cy_d;
        if (state_q == ST_IDLE) begin
            pbx = win_x;
            pby = win_y;
            pcx = '0;
            pcy = '0;
        end
    end

    assign sum_x         = {1'b0, pbx} + SXW'(pcx);
    assign sum_y         = {1'b0, pby} + SYW'(pcy);
    assign pix_in_screen = (sum_x < SXW'(XSCREEN)) && (sum_y < SYW'(YSCREEN));
    assign pix_last      = (pcx == CX_LAST) && (pcy == CY_LAST);

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            col_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            plot_q  <= 1'b0;
            vga_x_q <= '0;
            vga_y_q <= '0;
            vga_c_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    grant_q <= '0;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                    plot_q  <= 1'b0;
                    vga_x_q <= '0;
                    vga_y_q <= '0;
                    vga_c_q <= '0;
                    if (arb_valid) begin
                        state_q <= ST_DRAW;
                        bx_q    <= win_x;
                        by_q    <= win_y;
                        col_q   <= win_c;
                        owner_q <= arb_gnt;
                        ptr_q   <= (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
                        cx_q    <= '0;
                        cy_q    <= '0;
                        grant_q <= arb_gnt;
                        busy_q  <= 1'b1;
                        plot_q  <= pix_in_screen;
                        vga_x_q <= sum_x[XW-1:0];
                        vga_y_q <= sum_y[YW-1:0];
                        vga_c_q <= win_c;
                        done_q  <= pix_last ? arb_gnt : '0;
                    end
                end
                ST_DRAW: begin
                    grant_q <= '0;
                    if (cur_last) begin
                        // One bubble cycle in IDLE before the next arbitration.
                        state_q <= ST_IDLE;
                        cx_q    <= '0;
                        cy_q    <= '0;
                        done_q  <= '0;
                        busy_q  <= 1'b0;
                        plot_q  <= 1'b0;
                        vga_x_q <= '0;
                        vga_y_q <= '0;
                        vga_c_q <= '0;
                    end else begin
                        cx_q    <= cx_d;
                        cy_q    <= cy_d;
                        busy_q  <= 1'b1;
                        plot_q  <= pix_in_screen;
                        vga_x_q <= sum_x[XW-1:0];
                        vga_y_q <= sum_y[YW-1:0];
                        vga_c_q <= col_q;
                        done_q  <= pix_last ? owner_q : '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign plot      = plot_q;
    assign VGA_X     = vga_x_q;
    assign VGA_Y     = vga_y_q;
    assign VGA_COLOR = vga_c_q;

endmodule

`default_nettype wire

// File: tb/tb_box_plot_arbiter.sv
// ============================================================================
// Module : tb_box_plot_arbiter
// Brief  : Directed scoreboard bench for box_plot_arbiter (10x10 and 1x1 builds).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_box_plot_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  req;
    logic [23:0] rx;
    logic [20:0] ry;
    logic [8:0]  rc;
    logic [2:0]  grant, done;
    logic        busy, plot;
    logic [7:0]  vx;
    logic [6:0]  vy;
    logic [2:0]  vc;

    logic [2:0]  req1;
    logic [23:0] rx1;
    logic [20:0] ry1;
    logic [8:0]  rc1;
    logic [2:0]  grant1, done1;
    logic        busy1, plot1;
    logic [7:0]  vx1;
    logic [6:0]  vy1;
    logic [2:0]  vc1;

    always #5 clk = ~clk;

    box_plot_arbiter u_dut (
        .CLOCK_50 (clk), .Resetn (rstn), .req (req), .req_x (rx), .req_y (ry),
        .req_colour (rc), .grant (grant), .done (done), .busy (busy),
        .VGA_X (vx), .VGA_Y (vy), .VGA_COLOR (vc), .plot (plot)
    );

    box_plot_arbiter #(.XDIM(1), .YDIM(1)) u_dut1 (
        .CLOCK_50 (clk), .Resetn (rstn), .req (req1), .req_x (rx1), .req_y (ry1),
        .req_colour (rc1), .grant (grant1), .done (done1), .busy (busy1),
        .VGA_X (vx1), .VGA_Y (vy1), .VGA_COLOR (vc1), .plot (plot1)
    );

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       p;
        logic [2:0] g;
        logic [2:0] d;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   plot_cnt = 0;
    int   waited;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_op(input int w, input int x, input int y, input int c);
        rx[w*8 +: 8] = 8'(x);
        ry[w*7 +: 7] = 7'(y);
        rc[w*3 +: 3] = 3'(c);
    endtask

    task automatic push_box(input int w, input int bx, input int by, input int col,
                            input int xd, input int yd);
        exp_t e;
        int   sx, sy;
        for (int cy = 0; cy < yd; cy++) begin
            for (int cx = 0; cx < xd; cx++) begin
                sx  = bx + cx;
                sy  = by + cy;
                e.x = sx[7:0];
                e.y = sy[6:0];
                e.c = col[2:0];
                e.p = (sx < 160) && (sy < 120);
                e.g = (cx == 0 && cy == 0) ? 3'(1 << w) : 3'b000;
                e.d = (cx == xd - 1 && cy == yd - 1) ? 3'(1 << w) : 3'b000;
                q.push_back(e);
            end
        end
    endtask

    task automatic wait_busy(input int budget, output int n);
        n = 0;
        while (busy !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b1) chk("busy_timeout", 32'(busy), 32'd1);
    endtask

    task automatic draw_check(input int n, input bit drop, input int raise_at,
                              input logic [2:0] raise_mask, input bit bubble);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = q.pop_front();
            chk("vga_x", 32'(vx), 32'(e.x));
            chk("vga_y", 32'(vy), 32'(e.y));
            chk("vga_color", 32'(vc), 32'(e.c));
            chk("plot", 32'(plot), 32'(e.p));
            chk("grant", 32'(grant), 32'(e.g));
            chk("done", 32'(done), 32'(e.d));
            chk("busy", 32'(busy), 32'd1);
            if (plot === 1'b1) plot_cnt++;
            if (drop) req = req & ~grant;
            if (i == raise_at) req = req | raise_mask;
            @(negedge clk);
        end
        if (bubble) begin
            chk("bubble_busy", 32'(busy), 32'd0);
            chk("bubble_plot", 32'(plot), 32'd0);
            chk("bubble_grant", 32'(grant), 32'd0);
            chk("bubble_done", 32'(done), 32'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        req  = 3'b000;
        rx   = '0; ry = '0; rc = '0;
        req1 = 3'b000;
        rx1  = '0; ry1 = '0; rc1 = '0;
        repeat (2) @(negedge clk);

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_vga", {9'd0, vx, vy, vc, 5'd0}, 32'd0);

        // Two requesters held across reset release: strict 0,1,0,1 alternation.
        set_op(0, 20, 10, 1);
        set_op(1, 50, 40, 2);
        req  = 3'b011;
        rstn = 1'b1;
        for (int b = 0; b < 4; b++) begin
            wait_busy(5, waited);
            chk("t2_gap", 32'(waited), 32'd1);
            if (b % 2 == 0) push_box(0, 20, 10, 1, 10, 10);
            else            push_box(1, 50, 40, 2, 10, 10);
            draw_check(100, 1'b0, -1, 3'b000, 1'b1);
        end
        req = 3'b000;

        // Single box, requester drops after grant.
        set_op(0, 30, 30, 4);
        req = 3'b001;
        wait_busy(5, waited);
        chk("t1_latency", 32'(waited), 32'd1);
        push_box(0, 30, 30, 4, 10, 10);
        draw_check(100, 1'b1, -1, 3'b000, 1'b1);
        chk("t1_req_dropped", 32'(req), 32'd0);

        // Box straddling the bottom-right screen corner.
        set_op(0, 155, 115, 7);
        req      = 3'b001;
        plot_cnt = 0;
        wait_busy(5, waited);
        push_box(0, 155, 115, 7, 10, 10);
        draw_check(100, 1'b1, -1, 3'b000, 1'b1);
        chk("t3_plot_count", 32'(plot_cnt), 32'd25);

        // Requester 2 arrives mid-box and is served right after the bubble.
        set_op(0, 0, 0, 2);
        set_op(2, 100, 60, 5);
        req = 3'b001;
        wait_busy(5, waited);
        push_box(0, 0, 0, 2, 10, 10);
        draw_check(100, 1'b1, 50, 3'b100, 1'b1);
        wait_busy(5, waited);
        chk("t5_grant_gap", 32'(waited), 32'd1);
        push_box(2, 100, 60, 5, 10, 10);
        draw_check(100, 1'b1, -1, 3'b000, 1'b1);

        // Reset mid-box: outputs clear asynchronously, pointer returns to 0.
        set_op(0, 40, 20, 3);
        req = 3'b001;
        wait_busy(5, waited);
        push_box(0, 40, 20, 3, 10, 10);
        draw_check(37, 1'b1, -1, 3'b000, 1'b0);
        rstn = 1'b0;
        #1;
        chk("t4_async_busy", 32'(busy), 32'd0);
        chk("t4_async_plot", 32'(plot), 32'd0);
        chk("t4_async_done", 32'(done), 32'd0);
        chk("t4_async_vga", {9'd0, vx, vy, vc, 5'd0}, 32'd0);
        q.delete();
        @(negedge clk);
        chk("t4_held_done", 32'(done), 32'd0);
        req  = 3'b011;
        rstn = 1'b1;
        wait_busy(5, waited);
        chk("t4_restart_gap", 32'(waited), 32'd1);
        push_box(0, 40, 20, 3, 10, 10);
        draw_check(100, 1'b1, -1, 3'b000, 1'b1);
        wait_busy(5, waited);
        push_box(1, 50, 40, 2, 10, 10);
        draw_check(100, 1'b1, -1, 3'b000, 1'b1);
        chk("t4_reqs_cleared", 32'(req), 32'd0);

        // 1x1 box: grant and done coincide, no repeat service.
        rx1[15:8] = 8'd159;
        ry1[13:7] = 7'd119;
        rc1[5:3]  = 3'd5;
        req1      = 3'b010;
        @(negedge clk);
        chk("t6_grant", 32'(grant1), 32'b010);
        chk("t6_done", 32'(done1), 32'b010);
        chk("t6_plot", 32'(plot1), 32'd1);
        chk("t6_xy", {17'd0, vx1, vy1}, {17'd0, 8'd159, 7'd119});
        chk("t6_color", 32'(vc1), 32'd5);
        chk("t6_busy", 32'(busy1), 32'd1);
        req1 = req1 & ~grant1;
        @(negedge clk);
        chk("t6_bubble_busy", 32'(busy1), 32'd0);
        chk("t6_bubble_plot", 32'(plot1), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_regrant", 32'(grant1), 32'd0);
            chk("t6_no_replot", 32'(plot1), 32'd0);
        end

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
